stopwatch_lap_ctrl: RTL and testbench

Sequencing controller for the stopwatch datapath, covering the 100 Hz tick generator, the msec counter (0-99) and the sec counter (0-59).
- Owns the run/stop/lap/clear state machine.
- Gates the tick generator and produces the per-counter increment strobes, including the msec-to-sec cascade carry.
- Captures a lap snapshot and selects live or lap values for the FND display controller.
- Sits between the debounced button pulses and the counter, tick and display blocks.

---
 rtl/stopwatch_lap_ctrl.sv | 89 ++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencing controller: run/stop/lap/clear FSM, tick gating with
// msec-to-sec carry, lap snapshot capture and live/lap display selection.
module stopwatch_lap_ctrl #(
  parameter  int unsigned MSEC_MAX  = 100,
  parameter  int unsigned SEC_MAX   = 60,
  parameter  int unsigned LAP_CNT_W = 4,
  localparam int unsigned MSEC_W    = $clog2(MSEC_MAX),
  localparam int unsigned SEC_W     = $clog2(SEC_MAX)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run_stop,
  input  logic                 i_clear,
  input  logic                 i_lap,
  input  logic                 i_tick,
  input  logic [MSEC_W-1:0]    i_msec,
  input  logic [SEC_W-1:0]     i_sec,
  output logic                 o_tick_en,
  output logic                 o_clear,
  output logic                 o_msec_inc,
  output logic                 o_sec_inc,
  output logic [MSEC_W-1:0]    o_disp_msec,
  output logic [SEC_W-1:0]     o_disp_sec,
  output logic [LAP_CNT_W-1:0] o_lap_cnt,
  output logic [1:0]           o_state
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_LAP   = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  localparam logic [MSEC_W-1:0]    MSEC_LAST = MSEC_W'(MSEC_MAX - 1);
  localparam logic [LAP_CNT_W-1:0] LAP_SAT   = '1;

  state_t             state;
  logic [MSEC_W-1:0]  lap_msec;
  logic [SEC_W-1:0]   lap_sec;

  // State, snapshot and lap counter; button priority run_stop > lap > clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_STOP;
      lap_msec  <= '0;
      lap_sec   <= '0;
      o_lap_cnt <= '0;
    end else begin
      case (state)
        ST_STOP: begin
          if (i_run_stop)   state <= ST_RUN;
          else if (i_clear) state <= ST_CLEAR;
        end
        ST_RUN: begin
          if (i_run_stop) begin
            state <= ST_STOP;
          end else if (i_lap) begin
            state    <= ST_LAP;
            lap_msec <= i_msec;
            lap_sec  <= i_sec;
            if (o_lap_cnt != LAP_SAT) o_lap_cnt <= o_lap_cnt + LAP_CNT_W'(1);
          end
        end
        ST_LAP: begin
          if (i_run_stop) state <= ST_STOP;
          else if (i_lap) state <= ST_RUN;
        end
        ST_CLEAR: begin
          state     <= ST_STOP;
          lap_msec  <= '0;
          lap_sec   <= '0;
          o_lap_cnt <= '0;
        end
        default: state <= ST_STOP;
      endcase
    end
  end

  // Moore decodes plus zero-latency increment strobes
  assign o_state     = state;
  assign o_tick_en   = (state == ST_RUN) || (state == ST_LAP);
  assign o_clear     = (state == ST_CLEAR);
  assign o_msec_inc  = i_tick && o_tick_en;
  assign o_sec_inc   = o_msec_inc && (i_msec == MSEC_LAST);
  assign o_disp_msec = (state == ST_LAP) ? lap_msec : i_msec;
  assign o_disp_sec  = (state == ST_LAP) ? lap_sec  : i_sec;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: vector table for single-cycle
// behaviour plus sequences for lap saturation and mid-run reset.
module tb_stopwatch_lap_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_run_stop, i_clear, i_lap, i_tick;
  logic [6:0] i_msec;
  logic [5:0] i_sec;
  logic       o_tick_en, o_clear, o_msec_inc, o_sec_inc;
  logic [6:0] o_disp_msec;
  logic [5:0] o_disp_sec;
  logic [3:0] o_lap_cnt;
  logic [1:0] o_state;

  int n_cmp = 0;
  int n_err = 0;

  stopwatch_lap_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .i_run_stop  (i_run_stop),
    .i_clear     (i_clear),
    .i_lap       (i_lap),
    .i_tick      (i_tick),
    .i_msec      (i_msec),
    .i_sec       (i_sec),
    .o_tick_en   (o_tick_en),
    .o_clear     (o_clear),
    .o_msec_inc  (o_msec_inc),
    .o_sec_inc   (o_sec_inc),
    .o_disp_msec (o_disp_msec),
    .o_disp_sec  (o_disp_sec),
    .o_lap_cnt   (o_lap_cnt),
    .o_state     (o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs, cl, lp, tk, ms, se;
    int te, oc, mi, si, dm, ds, lc, st;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(int rs, int cl, int lp, int tk, int ms, int se,
                              int te, int oc, int mi, int si, int dm, int ds,
                              int lc, int st);
    vec_t v;
    v.rs = rs; v.cl = cl; v.lp = lp; v.tk = tk; v.ms = ms; v.se = se;
    v.te = te; v.oc = oc; v.mi = mi; v.si = si; v.dm = dm; v.ds = ds;
    v.lc = lc; v.st = st;
    return v;
  endfunction

  task automatic check(string name, int idx, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  task automatic set_in(int rs, int cl, int lp, int tk, int ms, int se);
    i_run_stop = 1'(rs);
    i_clear    = 1'(cl);
    i_lap      = 1'(lp);
    i_tick     = 1'(tk);
    i_msec     = 7'(ms);
    i_sec      = 6'(se);
  endtask

  task automatic check_all(int idx, vec_t v);
    check("tick_en",   idx, int'(o_tick_en),   v.te);
    check("clear",     idx, int'(o_clear),     v.oc);
    check("msec_inc",  idx, int'(o_msec_inc),  v.mi);
    check("sec_inc",   idx, int'(o_sec_inc),   v.si);
    check("disp_msec", idx, int'(o_disp_msec), v.dm);
    check("disp_sec",  idx, int'(o_disp_sec),  v.ds);
    check("lap_cnt",   idx, int'(o_lap_cnt),   v.lc);
    check("state",     idx, int'(o_state),     v.st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // rs cl lp tk  ms se | te oc mi si  dm ds lc st
    vecs[0]  = mk(0,0,0,1,  5,0,  0,0,0,0,  5,0,0,0);
    vecs[1]  = mk(0,0,1,0,  5,0,  0,0,0,0,  5,0,0,0);
    vecs[2]  = mk(1,0,0,0, 97,3,  0,0,0,0, 97,3,0,0);
    vecs[3]  = mk(0,0,0,1, 97,3,  1,0,1,0, 97,3,0,1);
    vecs[4]  = mk(0,0,0,1, 98,3,  1,0,1,0, 98,3,0,1);
    vecs[5]  = mk(0,0,0,1, 99,3,  1,0,1,1, 99,3,0,1);
    vecs[6]  = mk(0,0,0,1,  0,4,  1,0,1,0,  0,4,0,1);
    vecs[7]  = mk(0,0,0,1,  1,4,  1,0,1,0,  1,4,0,1);
    vecs[8]  = mk(0,0,0,0, 99,4,  1,0,0,0, 99,4,0,1);
    vecs[9]  = mk(0,0,1,0, 42,7,  1,0,0,0, 42,7,0,1);
    vecs[10] = mk(0,0,0,1, 43,7,  1,0,1,0, 42,7,1,2);
    vecs[11] = mk(0,1,0,0, 50,8,  1,0,0,0, 42,7,1,2);
    vecs[12] = mk(0,0,1,0, 51,8,  1,0,0,0, 42,7,1,2);
    vecs[13] = mk(0,0,0,0, 52,8,  1,0,0,0, 52,8,1,1);
    vecs[14] = mk(1,0,0,1, 53,8,  1,0,1,0, 53,8,1,1);
    vecs[15] = mk(0,0,0,1, 54,8,  0,0,0,0, 54,8,1,0);
    vecs[16] = mk(0,1,0,0, 54,8,  0,0,0,0, 54,8,1,0);
    vecs[17] = mk(1,0,0,1, 54,8,  0,1,0,0, 54,8,1,3);
    vecs[18] = mk(0,0,0,1, 54,8,  0,0,0,0, 54,8,0,0);
    vecs[19] = mk(1,0,0,0, 10,1,  0,0,0,0, 10,1,0,0);
    vecs[20] = mk(0,1,0,0, 10,1,  1,0,0,0, 10,1,0,1);
    vecs[21] = mk(1,0,1,0, 11,1,  1,0,0,0, 11,1,0,1);
    vecs[22] = mk(0,0,0,0, 12,1,  0,0,0,0, 12,1,0,0);
    vecs[23] = mk(1,0,0,0, 12,1,  0,0,0,0, 12,1,0,0);
    vecs[24] = mk(0,0,1,1, 20,2,  1,0,1,0, 20,2,0,1);
    vecs[25] = mk(1,0,0,1, 21,2,  1,0,1,0, 20,2,1,2);
    vecs[26] = mk(0,0,0,0, 22,2,  0,0,0,0, 22,2,1,0);

    // Reset held low for three cycles with pulses present
    reset = 1'b0;
    set_in(1, 1, 1, 1, 5, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 5, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].rs, vecs[i].cl, vecs[i].lp, vecs[i].tk, vecs[i].ms, vecs[i].se);
      @(negedge clk);
      check_all(i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Lap counter saturation: STOP with one lap taken, go to RUN then lap repeatedly
    set_in(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) begin
      set_in(0, 0, 1, 0, k, k);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0, k + 1, k + 1);
      @(negedge clk);
      check("sat_state", k, int'(o_state), 2);
      check("sat_lap_cnt", k, int'(o_lap_cnt), (k + 2 > 15) ? 15 : k + 2);
      check("sat_disp_msec", k, int'(o_disp_msec), k);
      set_in(0, 0, 1, 0, k + 1, k + 1);
      @(posedge clk); #1;
    end
    set_in(0, 0, 0, 1, 33, 5);
    @(negedge clk);
    check("sat_back_run", 0, int'(o_state), 1);

    // Reset mid-run overrides coincident pulses and tick
    @(posedge clk); #1;
    reset = 1'b0;
    set_in(1, 0, 1, 1, 30, 9);
    @(posedge clk); #1;
    reset = 1'b1;
    set_in(0, 0, 0, 1, 31, 9);
    @(negedge clk);
    check("rst_state", 0, int'(o_state), 0);
    check("rst_lap_cnt", 0, int'(o_lap_cnt), 0);
    check("rst_tick_en", 0, int'(o_tick_en), 0);
    check("rst_msec_inc", 0, int'(o_msec_inc), 0);
    check("rst_disp_msec", 0, int'(o_disp_msec), 31);
    check("rst_disp_sec", 0, int'(o_disp_sec), 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
